// File: rtl/serial_adder_if.sv
// Operand/result bus for the serial adder.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and
// its payload steady until that edge. The consumer may raise or drop ready
// freely. Inputs: in_valid/in_ready carry a, b, cin and sub. Results:
// out_valid/out_ready carry s, cout and ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. One DIGIT-bit ripple slice is reused
// for WIDTH/DIGIT cycles, least significant digit first. A carry flip-flop
// links the digits. For subtraction, b is inverted and the carry-in is
// flipped when the operands are accepted, so the slice only ever adds.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus,
    output logic            busy,
    output logic [1:0]      dbg_state
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_adder: DIGIT must evenly divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;
    logic             a_msb;
    logic             b_msb;
    logic [DIGIT-1:0] sum_dig;
    logic             carry_nxt;
    logic             last_dig;
    logic             in_ready_c;
    logic             out_valid_c;

    assign last_dig  = (cnt == CW'(N - 1));
    assign dbg_state = state;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.s         = s_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_dig) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One DIGIT-bit ripple slice on the low digit of the shifting operands.
    always_comb begin : digit_slice
        logic c;
        c       = carry;
        sum_dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum_dig[i] = a_r[i] ^ b_r[i] ^ c;
            c          = (a_r[i] & b_r[i]) | (a_r[i] & c) | (b_r[i] & c);
        end
        carry_nxt = c;
    end

    // Datapath: latch on acceptance, shift one digit per RUN cycle, and
    // capture cout/ovf on the last digit. Results hold until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.cin ^ bus.sub;
                        s_r   <= '0;
                        cnt   <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1] ^ bus.sub;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    // New digit enters at the top; after N cycles digit 0 sits at bit 0.
                    s_r   <= (s_r >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
                    carry <= carry_nxt;
                    if (last_dig) begin
                        cnt    <= '0;
                        cout_r <= carry_nxt;
                        ovf_r  <= (a_msb == b_msb) && (sum_dig[DIGIT-1] != a_msb);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
